// File: rtl/alu_seq_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: op codes, FSM states, slice width.
package alu_seq_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_NOTA  = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_CMP   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OP_SUB) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request/response bundle for alu_nibble_sequencer; req_cin exists only with ALU_SEQ_CARRY_IN_EN.
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 4);

    localparam int W = 4 * NIBBLES;

    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
`ifdef ALU_SEQ_CARRY_IN_EN
    logic           req_cin;
`endif
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_f;
    logic           rsp_cout;
    logic           rsp_zero;
    logic           rsp_ovf;

`ifdef ALU_SEQ_CARRY_IN_EN
    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_ovf
    );
    modport master (
        output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_ovf
    );
`else
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_ovf
    );
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero, rsp_ovf
    );
`endif

endinterface

// File: rtl/alu_seq_slice.sv
// Combinational 4-bit ALU slice; c3 is the carry into the slice MSB, used for signed overflow.
module alu_seq_slice
    import alu_seq_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    input  logic [2:0]       op,
    output logic [NIB_W-1:0] f,
    output logic             cout,
    output logic             c3
);

    logic [NIB_W-1:0] bx;
    logic [NIB_W:0]   sum;

    always_comb begin
        bx   = op_is_sub(op) ? ~b : b;
        sum  = {1'b0, a} + {1'b0, bx} + {{NIB_W{1'b0}}, cin};
        f    = '0;
        cout = 1'b0;
        c3   = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_CMP: begin
                f    = sum[NIB_W-1:0];
                cout = sum[NIB_W];
                // carry into bit 3 recovered from the sum bit and its two operand bits
                c3   = a[NIB_W-1] ^ bx[NIB_W-1] ^ sum[NIB_W-1];
            end
            OP_AND:   f = a & b;
            OP_OR:    f = a | b;
            OP_XOR:   f = a ^ b;
            OP_NOTA:  f = ~a;
            OP_PASSB: f = b;
            default:  f = '0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_sequencer.sv
// W-bit ALU built from one 4-bit slice stepped LSB nibble first, carry registered between nibbles.
// Optional carry/borrow-in port enabled by defining ALU_SEQ_CARRY_IN_EN.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_nibble_sequencer_if.slave bus,
    output logic                  busy
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t           state_q, state_d;
    logic [2:0]       op_q;
    logic [W-1:0]     a_q, b_q, res_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, zero_q, cout_q, ovf_q;

    logic [NIB_W-1:0] nib_a, nib_b, nib_f;
    logic             nib_cout, nib_c3;
    logic             accept, last, cin_init;

    assign accept = bus.req_valid && (state_q == ST_IDLE);
    assign last   = (idx_q == IDX_W'(NIBBLES - 1));
    assign nib_a  = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_b  = b_q[idx_q*NIB_W +: NIB_W];

`ifdef ALU_SEQ_CARRY_IN_EN
    // req_cin is a carry-in for ADD and a borrow-in for SUB/CMP
    assign cin_init = op_is_sub(bus.req_op) ? ~bus.req_cin :
                      (bus.req_op == OP_ADD) ? bus.req_cin : 1'b0;
`else
    assign cin_init = op_is_sub(bus.req_op);
`endif

    alu_seq_slice u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .op   (op_q),
        .f    (nib_f),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.req_valid) state_d = ST_RUN;
            ST_RUN:  if (last)          state_d = ST_DONE;
            ST_DONE: if (bus.rsp_ready) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_DONE);
        busy          = (state_q == ST_RUN);
        bus.rsp_f     = res_q;
        bus.rsp_cout  = cout_q;
        bus.rsp_ovf   = ovf_q;
        bus.rsp_zero  = (state_q == ST_DONE) && zero_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            op_q    <= bus.req_op;
            a_q     <= bus.req_a;
            b_q     <= bus.req_b;
            res_q   <= '0;
            idx_q   <= '0;
            carry_q <= cin_init;
            zero_q  <= 1'b1;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (state_q == ST_RUN) begin
            // CMP keeps the result cleared but still tracks flags of the difference
            if (op_q != OP_CMP) res_q[idx_q*NIB_W +: NIB_W] <= nib_f;
            carry_q <= nib_cout;
            zero_q  <= zero_q && (nib_f == '0);
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                cout_q <= nib_cout;
                ovf_q  <= nib_c3 ^ nib_cout;
            end
        end
    end

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Scoreboard bench for alu_nibble_sequencer: directed corner cases plus randomized ops vs a reference model.
module tb_alu_nibble_sequencer;
    import alu_seq_pkg::*;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] f;
        logic         cout;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rdy_mode = 2;
    exp_t sb[$];

    alu_nibble_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    alu_nibble_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: whole-word integer arithmetic, cin is carry-in for ADD and borrow-in for SUB/CMP
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        exp_t   e;
        longint ua, ub, sa, sbv, t, s, c;
        longint maxs, mins;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sbv  = longint'($signed(b));
        c    = longint'(cin);
        maxs = (longint'(1) <<< (W - 1)) - 1;
        mins = -(longint'(1) <<< (W - 1));
        e.f = '0; e.cout = 1'b0; e.zero = 1'b0; e.ovf = 1'b0;
        case (op)
            OP_ADD: begin
                t = ua + ub + c;
                s = sa + sbv + c;
                e.f    = W'(t);
                e.cout = (t >= (longint'(1) <<< W));
                e.ovf  = (s > maxs) || (s < mins);
                e.zero = (e.f == '0);
            end
            OP_SUB, OP_CMP: begin
                t = ua - ub - c;
                s = sa - sbv - c;
                e.f    = (op == OP_CMP) ? '0 : W'(t);
                e.cout = (t >= 0);
                e.ovf  = (s > maxs) || (s < mins);
                e.zero = (W'(t) == '0);
            end
            OP_AND:   begin e.f = a & b; e.zero = (e.f == '0); end
            OP_OR:    begin e.f = a | b; e.zero = (e.f == '0); end
            OP_XOR:   begin e.f = a ^ b; e.zero = (e.f == '0); end
            OP_NOTA:  begin e.f = ~a;    e.zero = (e.f == '0); end
            default:  begin e.f = b;     e.zero = (e.f == '0); end
        endcase
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit chk_lat);
        int waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready) begin
            chk("req_ready_wait", 64'(bus.req_ready), 64'(1));
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.req_cin   = cin;
`endif
        @(posedge clk);
        sb.push_back(model(op, a, b, cin));
        #1;
        bus.req_valid = 1'b0;
        bus.req_a     = W'($urandom);
        bus.req_b     = W'($urandom);
        bus.req_op    = 3'($urandom);
        chk("busy_after_accept", 64'(busy), 64'(1));
        if (chk_lat) begin
            for (int k = 1; k <= NIBBLES; k++) begin
                @(posedge clk);
                #1;
                chk("latency_rsp_valid", 64'(bus.rsp_valid), 64'(k == NIBBLES));
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.rsp_ready = ($urandom_range(0, 3) != 0);
            1:       bus.rsp_ready = 1'b0;
            default: bus.rsp_ready = 1'b1;
        endcase
    end

    // Monitor: every presented response must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 64'(bus.rsp_valid), 64'(0));
            end else begin
                chk("rsp_f",    64'(bus.rsp_f),    64'(sb[0].f));
                chk("rsp_cout", 64'(bus.rsp_cout), 64'(sb[0].cout));
                chk("rsp_zero", 64'(bus.rsp_zero), 64'(sb[0].zero));
                chk("rsp_ovf",  64'(bus.rsp_ovf),  64'(sb[0].ovf));
                if (bus.rsp_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         cin;
        bus.req_valid = 1'b0;
        bus.req_op    = OP_ADD;
        bus.req_a     = '0;
        bus.req_b     = '0;
`ifdef ALU_SEQ_CARRY_IN_EN
        bus.req_cin   = 1'b0;
`endif
        #1;
        chk("reset_req_ready", 64'(bus.req_ready), 64'(1));
        chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("reset_busy",      64'(busy),          64'(0));
        chk("reset_rsp_f",     64'(bus.rsp_f),     64'(0));
        chk("reset_flags",     64'({bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf}), 64'(0));
        #11 rst_n = 1'b1;

        send(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
        send(OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b1);
        send(OP_CMP, 16'h1234, 16'h1234, 1'b0, 1'b1);
        send(OP_CMP, 16'h0001, 16'h0002, 1'b0, 1'b1);
        send(OP_XOR, 16'hA5A5, 16'hFFFF, 1'b0, 1'b1);

        // Hold the response: nothing may move or be accepted while rsp_ready is low
        @(negedge clk);
        rdy_mode = 1;
        send(OP_OR, 16'h1200, 16'h0034, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = 3'($urandom);
            bus.req_a     = W'($urandom);
            bus.req_b     = W'($urandom);
            @(posedge clk);
            #1;
            chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
            chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
            chk("hold_busy",      64'(busy),          64'(0));
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        rdy_mode = 2;
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("release_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("release_req_ready", 64'(bus.req_ready), 64'(1));
        chk("release_sb_empty",  64'(sb.size()),     64'(0));

        // Reset mid-RUN at nibble index 2: response is dropped
        send(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 64'(bus.req_ready), 64'(1));
        chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
        chk("midrst_busy",      64'(busy),          64'(0));
        chk("midrst_rsp_f",     64'(bus.rsp_f),     64'(0));
        chk("midrst_flags",     64'({bus.rsp_cout, bus.rsp_zero, bus.rsp_ovf}), 64'(0));
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (NIBBLES + 2) @(posedge clk);
        send(OP_ADD, 16'h0F0F, 16'h00F1, 1'b0, 1'b1);

        rdy_mode = 0;
        for (int i = 0; i < 60; i++) begin
            op  = 3'($urandom_range(0, 7));
            a   = W'($urandom);
            case ($urandom_range(0, 5))
                0:       b = a;
                1:       b = 16'h8000;
                2:       b = 16'hFFFF;
                default: b = W'($urandom);
            endcase
`ifdef ALU_SEQ_CARRY_IN_EN
            cin = 1'($urandom);
`else
            cin = 1'b0;
`endif
            send(op, a, b, cin, bit'($urandom_range(0, 1)));
        end

        rdy_mode = 2;
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
        chk("drain_sb_empty", 64'(sb.size()), 64'(0));
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
